// File: rtl/turn_sequencer.sv
// turn_sequencer: turn order, track positions and tail captures for the chicken-chase game
module turn_sequencer #(
  parameter int TRACK_LEN = 24,
  parameter int POS_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_i,
  input  logic [2:0]         nplayers_i,
  input  logic               move_i,
  input  logic               miss_i,
  output logic               ready_o,
  output logic [1:0]         cur_player_o,
  output logic [4*POS_W-1:0] pos_bus_o,
  output logic [11:0]        tails_bus_o,
  output logic               win_o,
  output logic [1:0]         winner_o
);
  typedef enum logic [2:0] {IDLE, SETUP, PLAY, MOVE, RESOLVE, WON} state_t;
  localparam logic [POS_W-1:0] LAST = POS_W'(TRACK_LEN - 1);
  state_t           state_q;
  logic [2:0]       n_q, n_d;
  logic [1:0]       cur_q, cur_d, winner_q, jsel;
  logic [POS_W-1:0] pos_q [4];
  logic [2:0]       tails_q [4];
  logic [POS_W-1:0] step, pos_d;
  logic [2:0]       tails_d;
  logic             win_q, found;
  assign n_d     = nplayers_i < 3'd2 ? 3'd2 : nplayers_i > 3'd4 ? 3'd4 : nplayers_i;
  assign step    = n_q == 3'd2 ? POS_W'(TRACK_LEN / 2) : n_q == 3'd3 ? POS_W'(TRACK_LEN / 3) : POS_W'(TRACK_LEN / 4);
  assign cur_d   = {1'b0, cur_q} + 3'd1 == n_q ? 2'd0 : cur_q + 2'd1;
  assign pos_d   = pos_q[cur_q] == LAST ? '0 : pos_q[cur_q] + 1'b1;
  assign tails_d = tails_q[cur_q] + (found ? tails_q[jsel] : 3'd0);
  // descending scan so the lowest-index victim is the one kept
  always_comb begin
    found = 1'b0;
    jsel  = 2'd0;
    for (int j = 3; j >= 0; j--)
      if (2'(j) != cur_q && 3'(j) < n_q && tails_q[j] != 3'd0 && pos_q[j] == pos_q[cur_q]) begin
        found = 1'b1;
        jsel  = 2'(j);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= 3'd2;
      cur_q    <= 2'd0;
      win_q    <= 1'b0;
      winner_q <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        pos_q[i]   <= '0;
        tails_q[i] <= 3'd0;
      end
    end else if (init_i) begin
      state_q <= SETUP;
      n_q     <= n_d;
      win_q   <= 1'b0;
    end else begin
      case (state_q)
        SETUP: begin
          for (int i = 0; i < 4; i++) begin
            pos_q[i]   <= 3'(i) < n_q ? POS_W'(i) * step : '0;
            tails_q[i] <= 3'(i) < n_q ? 3'd1 : 3'd0;
          end
          cur_q   <= 2'd0;
          state_q <= PLAY;
        end
        PLAY: begin
          if (move_i) state_q <= MOVE;
          else if (miss_i) cur_q <= cur_d;
        end
        MOVE: begin
          pos_q[cur_q] <= pos_d;
          state_q      <= RESOLVE;
        end
        RESOLVE: begin
          tails_q[cur_q] <= tails_d;
          if (found) tails_q[jsel] <= 3'd0;
          if (tails_d == n_q) begin
            state_q  <= WON;
            win_q    <= 1'b1;
            winner_q <= cur_q;
          end else state_q <= PLAY;
        end
        default: ;
      endcase
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign pos_bus_o[g*POS_W +: POS_W] = pos_q[g];
    assign tails_bus_o[g*3 +: 3]       = tails_q[g];
  end
  assign ready_o      = state_q == PLAY;
  assign cur_player_o = cur_q;
  assign win_o        = win_q;
  assign winner_o     = winner_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed plus random checks against a transaction-level game model
module tb_turn_sequencer;
  logic        clk = 0, rst = 0, init = 0, move = 0, miss = 0;
  logic [2:0]  nplayers = 0;
  logic        ready, win;
  logic [1:0]  cur_player, winner;
  logic [19:0] pos_bus;
  logic [11:0] tails_bus;
  int checks = 0, errors = 0;
  int mn, mcur, mwin, mwinner, mst;
  int mpos [4];
  int mtails [4];

  turn_sequencer #(.TRACK_LEN(24), .POS_W(5)) dut (
    .clk(clk), .rst(rst), .init_i(init), .nplayers_i(nplayers), .move_i(move), .miss_i(miss),
    .ready_o(ready), .cur_player_o(cur_player), .pos_bus_o(pos_bus), .tails_bus_o(tails_bus),
    .win_o(win), .winner_o(winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mn = 2; mcur = 0; mwin = 0; mwinner = 0; mst = 0;
    for (int i = 0; i < 4; i++) begin mpos[i] = 0; mtails[i] = 0; end
  endtask

  task automatic m_init(input int np);
    mn = np < 2 ? 2 : np > 4 ? 4 : np;
    for (int i = 0; i < 4; i++) begin
      mpos[i] = i < mn ? i * (24 / mn) : 0;
      mtails[i] = i < mn ? 1 : 0;
    end
    mcur = 0; mwin = 0; mst = 1;
  endtask

  task automatic m_resolve();
    for (int j = 0; j < mn; j++)
      if (j != mcur && mtails[j] != 0 && mpos[j] == mpos[mcur]) begin
        mtails[mcur] += mtails[j];
        mtails[j] = 0;
        break;
      end
    if (mtails[mcur] == mn) begin mwin = 1; mwinner = mcur; mst = 2; end
  endtask

  task automatic check_all(input string tag);
    logic [19:0] ep;
    logic [11:0] et;
    for (int i = 0; i < 4; i++) begin
      ep[i*5 +: 5] = 5'(mpos[i]);
      et[i*3 +: 3] = 3'(mtails[i]);
    end
    cmp({tag, ".ready"}, 32'(ready), 32'(mst == 1));
    cmp({tag, ".cur"}, 32'(cur_player), 32'(mcur));
    cmp({tag, ".pos"}, 32'(pos_bus), 32'(ep));
    cmp({tag, ".tails"}, 32'(tails_bus), 32'(et));
    cmp({tag, ".win"}, 32'(win), 32'(mwin));
    if (mwin != 0) cmp({tag, ".winner"}, 32'(winner), 32'(mwinner));
  endtask

  task automatic do_init(input int np);
    nplayers = 3'(np); init = 1; tick(); init = 0;
    cmp("init.setup_ready", 32'(ready), 32'd0);
    cmp("init.win_clear", 32'(win), 32'd0);
    tick();
    m_init(np);
    check_all("init");
  endtask

  task automatic do_miss();
    miss = 1; tick(); miss = 0;
    if (mst == 1) mcur = (mcur + 1) % mn;
    check_all("miss");
  endtask

  task automatic do_move(input bit with_miss);
    logic [19:0] ep;
    move = 1; miss = with_miss; tick(); move = 0; miss = 0;
    if (mst == 1) begin
      cmp("move.busy1", 32'(ready), 32'd0);
      tick();
      mpos[mcur] = (mpos[mcur] + 1) % 24;
      for (int i = 0; i < 4; i++) ep[i*5 +: 5] = 5'(mpos[i]);
      cmp("move.busy2", 32'(ready), 32'd0);
      cmp("move.pos_early", 32'(pos_bus), 32'(ep));
      tick();
      m_resolve();
    end else begin
      tick(); tick();
    end
    check_all(with_miss ? "move_miss" : "move");
  endtask

  initial begin
    m_reset();
    rst = 1; tick(); tick(); rst = 0;
    check_all("reset");
    do_miss();
    do_move(0);
    do_init(3);
    do_init(2);
    do_miss();
    do_miss();
    do_move(1);
    do_init(2);
    do_miss();
    for (int i = 0; i < 11; i++) do_move(0);
    cmp("wrap.pre_pos1", 32'(pos_bus[9:5]), 32'd23);
    do_move(0);
    cmp("wrap.pos1", 32'(pos_bus[9:5]), 32'd0);
    cmp("wrap.tails", 32'(tails_bus), 32'h010);
    cmp("wrap.win", 32'(win), 32'd1);
    cmp("wrap.winner", 32'(winner), 32'd1);
    do_miss();
    do_move(0);
    do_init(7);
    do_init(1);
    nplayers = 3'd3; rst = 1; init = 1; tick(); rst = 0; init = 0;
    m_reset();
    check_all("rst_init");
    tick();
    check_all("rst_init_hold");
    do_init(4);
    move = 1; tick(); move = 0;
    nplayers = 3'd4; init = 1; tick(); init = 0;
    cmp("abort.setup_ready", 32'(ready), 32'd0);
    tick();
    m_init(4);
    check_all("abort");
    for (int k = 0; k < 300; k++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) do_init(int'($urandom_range(0, 7)));
      else if (r < 7) do_miss();
      else if (r < 18) do_move(0);
      else do_move(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
